// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32 fetch stage: PC, imem req/ack handshake, instruction FIFO to decode.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        CLK,
   input  logic        RST,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   output logic        fetch_fault,
   output logic [31:0] fault_pc
);

   localparam int            PW      = $clog2(FIFO_DEPTH);
   localparam int            CW      = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_FLUSH = 2'd1
`ifdef FETCH_MISALIGN_CHECK_EN
      , S_FAULT = 2'd2
`endif
   } state_t;

   state_t          r_state;
   state_t          w_state_next;

   logic [31:0]     r_pc;
   logic            r_req;
   logic [31:0]     r_addr;
   logic [31:0]     r_fifo_inst [FIFO_DEPTH];
   logic [31:0]     r_fifo_pc   [FIFO_DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;

   logic            w_ack;
   logic            w_busy_next;
   logic            w_push;
   logic            w_pop;
   logic            w_issue;
   logic [CW-1:0]   w_count_next;
   logic [31:0]     w_pc_next;
   logic [31:0]     w_redirect_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic            w_misalign;
   logic            r_fault;
   logic [31:0]     r_fault_pc;

   assign w_misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
`endif

   // An ack with no request outstanding (e.g. one that straddles a reset) is ignored.
   assign w_ack       = imem_ack && r_req;
   assign w_busy_next = r_req && !w_ack;
   assign w_push      = w_ack && (r_state == S_FETCH) && !redirect_valid;
   assign w_pop       = inst_valid && inst_ready && !redirect_valid;

   // Fetch is word-granular, so the low redirect bits never reach the PC.
   assign w_redirect_pc = {redirect_pc[31:2], redirect_pc[1:0] & 2'b00};

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (redirect_valid) begin
         if (w_busy_next) begin
            w_state_next = S_FLUSH;
         end else begin
            w_state_next = S_FETCH;
         end
`ifdef FETCH_MISALIGN_CHECK_EN
         if (w_misalign) begin
            w_state_next = S_FAULT;
         end
`endif
      end else if ((r_state == S_FLUSH) && w_ack) begin
         w_state_next = S_FETCH;
      end
   end

   always_comb begin
      w_count_next = r_count;
      w_pc_next    = r_pc;
      if (redirect_valid) begin
         w_count_next = '0;
         w_pc_next    = w_redirect_pc;
      end else begin
         if (w_push) begin
            w_count_next = w_count_next + CW'(1);
            w_pc_next    = r_pc + 32'd4;
         end
         if (w_pop) begin
            w_count_next = w_count_next - CW'(1);
         end
      end
   end

   // A new request is decided on next-cycle state, which also yields back-to-back issue on an ack.
   assign w_issue = !w_busy_next && (w_state_next == S_FETCH) && (w_count_next < DEPTH_C);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_pc     <= RESET_PC;
         r_req    <= 1'b0;
         r_addr   <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_pc    <= w_pc_next;
         r_count <= w_count_next;
         r_req   <= w_busy_next || w_issue;
         if (w_issue) begin
            r_addr <= w_pc_next;
         end
         if (redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + PW'(1);
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_fifo_inst[r_wr_ptr] <= imem_rdata;
         r_fifo_pc[r_wr_ptr]   <= r_addr;
      end
   end

   assign imem_req   = r_req;
   assign imem_addr  = r_addr;
   assign inst_valid = (r_count != '0);
   assign inst       = inst_valid ? r_fifo_inst[r_rd_ptr] : 32'd0;
   assign inst_pc    = inst_valid ? r_fifo_pc[r_rd_ptr]   : 32'd0;

`ifdef FETCH_MISALIGN_CHECK_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_fault    <= 1'b0;
         r_fault_pc <= '0;
      end else if (redirect_valid) begin
         r_fault <= w_misalign;
         if (w_misalign) begin
            r_fault_pc <= redirect_pc;
         end
      end
   end

   assign fetch_fault = r_fault;
   assign fault_pc    = r_fault_pc;
`else
   assign fetch_fault = 1'b0;
   assign fault_pc    = 32'd0;
`endif

endmodule
